// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM states, halt opcode
// and the per-program base address table.
package program_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [8:0] HALT_INSTR = 9'b010000000;

   localparam int unsigned NUM_BASES = 3;
   localparam int unsigned PROG_BASE [NUM_BASES] = '{0, 256, 512};

   // Programs beyond the table fall back to address 0.
   function automatic int unsigned prog_base(input int unsigned idx);
      case (idx)
         0:       return PROG_BASE[0];
         1:       return PROG_BASE[1];
         2:       return PROG_BASE[2];
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Host/core-facing signal bundle of the program sequencer.
interface program_sequencer_if #(
   parameter int unsigned PC_W    = 10,
   parameter int unsigned INSTR_W = 9,
   parameter int unsigned IDX_W   = 2
);
   logic               start;
   logic [INSTR_W-1:0] instr;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_target;
   logic [PC_W-1:0]    pc;
   logic               core_en;
   logic [IDX_W-1:0]   prog_idx;
   logic               done;
   logic               timeout;

   modport master (
      output start, instr, branch_taken, branch_target,
      input  pc, core_en, prog_idx, done, timeout
   );

   modport slave (
      input  start, instr, branch_taken, branch_target,
      output pc, core_en, prog_idx, done, timeout
   );
endinterface

// File: rtl/program_sequencer_cycle_watchdog.sv
// Per-program RUN-cycle counter; expired flags the last permitted cycle.
module cycle_watchdog #(
   parameter int unsigned MAX_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == CNT_W'(MAX_CYCLES - 1));

   // Saturate at the limit so the count never wraps back into range.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && !expired_o)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/program_sequencer.sv
// Launches programs in turn from a base address table, steps the fetch address
// until halt or watchdog expiry, and reports completion to the host.
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int unsigned NUM_PROGS  = 3,
   parameter int unsigned PC_W       = 10,
   parameter int unsigned INSTR_W    = 9,
   parameter int unsigned MAX_CYCLES = 4096
) (
   input logic                clk,
   input logic                reset,
   program_sequencer_if.slave bus
);
   localparam int unsigned IDX_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
   localparam logic [INSTR_W-1:0] HALT = INSTR_W'(HALT_INSTR);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_next;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             is_halt;
   logic             wd_clear, wd_en, wd_expired;

   assign is_halt  = (bus.instr == HALT);
   assign idx_next = (idx_q == IDX_W'(NUM_PROGS - 1)) ? '0 : idx_q + IDX_W'(1);
   assign wd_en    = (state_q == RUN);

   cycle_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (wd_clear),
      .enable_i  (wd_en),
      .expired_o (wd_expired)
   );

   // Next-state logic; halt is tested before the watchdog so it wins a tie.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      idx_d     = idx_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      wd_clear  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d   = ARMED;
               done_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         ARMED: begin
            if (!bus.start) begin
               state_d  = RUN;
               pc_d     = PC_W'(prog_base(32'(idx_q)));
               wd_clear = 1'b1;
            end
         end
         RUN: begin
            if (is_halt) begin
               state_d = DONE;
               done_d  = 1'b1;
               idx_d   = idx_next;
            end else if (wd_expired) begin
               state_d   = DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               idx_d     = idx_next;
            end else if (bus.branch_taken) begin
               pc_d = bus.branch_target;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   // core_en follows the fetched instruction directly so a halt never writes.
   assign bus.core_en  = (state_q == RUN) && !is_halt;
   assign bus.pc       = pc_q;
   assign bus.prog_idx = idx_q;
   assign bus.done     = done_q;
   assign bus.timeout  = timeout_q;
endmodule
